phys_reg_file_mp: RTL
=====================

Name: phys_reg_file_mp

Overview:
- Parametrised successor to the 256-entry physical register file used by rename/issue.
- Configurable data width, depth, read-port count, writeback-port count and allocate-port count.
- Adds same-cycle writeback-to-read bypass, optional registered read, a flush that re-validates all entries, and a sticky multi-writer error flag.
- Sits between rename (allocates destinations) and the issue queues / execution units (read operands, write back results).

Parameters:
- DATA_W, 32, register data width.
- NUM_PREGS, 256, physical register count; power of two, ≥ 64.
- PREG_W, 8, physical index width = log2(NUM_PREGS).
- NUM_ARCH, 32, architectural registers preloaded at reset.
- NUM_RD, 2, read ports.
- NUM_WB, 5, writeback ports (add, load, mul, div, done order).
- NUM_ALLOC, 1, destination-allocate ports.
- BYPASS, 1, 1 = writeback data forwarded to same-cycle reads.
- READ_REG, 0, 0 = combinational read; 1 = read outputs registered (1-cycle latency).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NUM_RD*PREG_W  read indices, port k at bits [k*PREG_W +: PREG_W].
- rd_data  out  NUM_RD*DATA_W  read data per port.
- rd_valid  out  NUM_RD  valid bit per port.
- wb_en  in  NUM_WB  writeback enables.
- wb_addr  in  NUM_WB*PREG_W  writeback destination indices.
- wb_data  in  NUM_WB*DATA_W  writeback data.
- alloc_en  in  NUM_ALLOC  allocate-destination strobes.
- alloc_addr  in  NUM_ALLOC*PREG_W  newly renamed destination indices.
- flush  in  1  misprediction recovery; sets every valid bit to 1.
- err_multi_wr  out  1  sticky: two enabled wb ports hit the same nonzero index in one cycle.
- valid_cnt  out  PREG_W+1  registered count of valid entries.

Behaviour:
- Reset (reset=0, async, takes effect immediately, including mid-cycle):
  - entry i < NUM_ARCH: data = i, valid = 1.
  - all other entries: data = 0, valid = 1.
  - err_multi_wr = 0; valid_cnt = NUM_PREGS; registered rd_data = 0, rd_valid = 0.
- Entry 0: data always 0, valid always 1. Writes and allocates to index 0 are ignored.
- Writeback (posedge clk): each wb_en[j] with wb_addr[j] ≠ 0 writes data and sets valid = 1.
- Allocate (posedge clk): each alloc_en[k] with alloc_addr[k] ≠ 0 clears valid; data is unchanged.
- Same-index priority within one cycle:
  - allocate clear beats writeback set on valid; data is still written.
  - two wb ports on the same index: lowest j wins data; err_multi_wr set, held until reset.
  - flush beats allocate and writeback on valid (all valid = 1); wb data still written; allocates that cycle are discarded.
- Read, READ_REG = 0: rd_data/rd_valid are combinational from storage. If BYPASS = 1 and an enabled wb port matches rd_addr (nonzero), output that wb_data (lowest j) with valid = 1.
- Read, READ_REG = 1: outputs registered at posedge. They reflect storage after this edge's writeback and allocate, i.e. data from cycle t appears at t+1. BYPASS is implied.
- rd_addr = 0 always returns data 0, valid 1.
- valid_cnt: registered popcount of valid bits after each edge's updates; range 0..NUM_PREGS.
- Indices ≥ NUM_PREGS cannot occur because PREG_W = log2(NUM_PREGS).

Test Plan:
- Reset, then READ_REG = 0: rd_addr = {5, 40} -> rd_data = {5, 0}, rd_valid = {1, 1}, valid_cnt = 256, err_multi_wr = 0.
- alloc_addr = 40 at edge 1; wb port 2 writes 40 with 0xDEADBEEF at edge 3; read 40 -> valid 0 after edge 1; during cycle 3 bypass gives 0xDEADBEEF, valid 1; after edge 3 storage gives the same; valid_cnt goes 255 -> 256.
- Same edge: alloc 50 and wb port 0 writes 50 = 0x1234 -> entry 50 data 0x1234, valid 0.
- wb ports 1 and 3 both target 60 with 0xAAAA and 0xBBBB -> data 0xAAAA; err_multi_wr = 1 and stays 1 through 10 idle cycles.
- Allocate 70..79, then flush together with alloc 80 -> all valid = 1, entry 80 valid = 1, valid_cnt = 256.
- wb to index 0 with 0xFFFF -> read 0 gives 0, valid 1. Assert reset mid-burst -> outputs return to reset values without waiting for a clock edge. With READ_REG = 1, read data appears exactly one cycle after the writeback edge.

Source files
------------

// File: rtl/phys_reg_file_mp.sv
// Physical register file with multi-port writeback, allocate-clears-valid, flush,
// optional writeback-to-read bypass and optional registered read outputs.
module phys_reg_file_mp #(
  parameter int DATA_W    = 32,
  parameter int NUM_PREGS = 256,
  parameter int PREG_W    = 8,
  parameter int NUM_ARCH  = 32,
  parameter int NUM_RD    = 2,
  parameter int NUM_WB    = 5,
  parameter int NUM_ALLOC = 1,
  parameter int BYPASS    = 1,
  parameter int READ_REG  = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_RD*PREG_W-1:0]    rd_addr,
  output logic [NUM_RD*DATA_W-1:0]    rd_data,
  output logic [NUM_RD-1:0]           rd_valid,
  input  logic [NUM_WB-1:0]           wb_en,
  input  logic [NUM_WB*PREG_W-1:0]    wb_addr,
  input  logic [NUM_WB*DATA_W-1:0]    wb_data,
  input  logic [NUM_ALLOC-1:0]        alloc_en,
  input  logic [NUM_ALLOC*PREG_W-1:0] alloc_addr,
  input  logic                        flush,
  output logic                        err_multi_wr,
  output logic [PREG_W:0]             valid_cnt
);

  localparam int CNT_W = PREG_W + 1;

  logic [DATA_W-1:0]    mem [NUM_PREGS];
  logic [NUM_PREGS-1:0] vld;
  logic [NUM_PREGS-1:0] vld_nxt;
  logic                 multi_hit;

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_PREGS-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_PREGS; i++) cnt = cnt + CNT_W'(v[i]);
    return cnt;
  endfunction

  // Allocate clears after writeback sets; flush overrides both; entry 0 is pinned valid.
  always_comb begin
    vld_nxt = vld;
    for (int j = 0; j < NUM_WB; j++)
      if (wb_en[j] && wb_addr[j*PREG_W +: PREG_W] != '0)
        vld_nxt[wb_addr[j*PREG_W +: PREG_W]] = 1'b1;
    for (int k = 0; k < NUM_ALLOC; k++)
      if (alloc_en[k] && alloc_addr[k*PREG_W +: PREG_W] != '0)
        vld_nxt[alloc_addr[k*PREG_W +: PREG_W]] = 1'b0;
    if (flush) vld_nxt = '1;
    vld_nxt[0] = 1'b1;
  end

  always_comb begin
    multi_hit = 1'b0;
    for (int j = 0; j < NUM_WB; j++)
      for (int k = j + 1; k < NUM_WB; k++)
        if (wb_en[j] && wb_en[k] && wb_addr[j*PREG_W +: PREG_W] == wb_addr[k*PREG_W +: PREG_W]
            && wb_addr[j*PREG_W +: PREG_W] != '0)
          multi_hit = 1'b1;
  end

  // ---- storage update stage ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PREGS; i++) mem[i] <= (i < NUM_ARCH) ? DATA_W'(i) : '0;
      vld          <= '1;
      err_multi_wr <= 1'b0;
      valid_cnt    <= CNT_W'(NUM_PREGS);
    end else begin
      // Descending order so the lowest-numbered port's write lands last and wins.
      for (int j = NUM_WB - 1; j >= 0; j--)
        if (wb_en[j] && wb_addr[j*PREG_W +: PREG_W] != '0)
          mem[wb_addr[j*PREG_W +: PREG_W]] <= wb_data[j*DATA_W +: DATA_W];
      vld       <= vld_nxt;
      valid_cnt <= popcount(vld_nxt);
      if (multi_hit) err_multi_wr <= 1'b1;
    end
  end

  if (READ_REG == 0) begin : g_comb_rd
    always_comb begin
      rd_data  = '0;
      rd_valid = '0;
      for (int p = 0; p < NUM_RD; p++) begin
        rd_data[p*DATA_W +: DATA_W] = mem[rd_addr[p*PREG_W +: PREG_W]];
        rd_valid[p]                 = vld[rd_addr[p*PREG_W +: PREG_W]];
        if (BYPASS != 0)
          for (int j = NUM_WB - 1; j >= 0; j--)
            if (wb_en[j] && wb_addr[j*PREG_W +: PREG_W] == rd_addr[p*PREG_W +: PREG_W]) begin
              rd_data[p*DATA_W +: DATA_W] = wb_data[j*DATA_W +: DATA_W];
              rd_valid[p]                 = 1'b1;
            end
        if (rd_addr[p*PREG_W +: PREG_W] == '0) begin
          rd_data[p*DATA_W +: DATA_W] = '0;
          rd_valid[p]                 = 1'b1;
        end
      end
    end
  end else begin : g_reg_rd
    logic [NUM_RD*DATA_W-1:0] rd_data_p0;
    logic [NUM_RD-1:0]        rd_valid_p0;
    logic [NUM_RD*DATA_W-1:0] rd_data_p1;
    logic [NUM_RD-1:0]        rd_valid_p1;

    // Post-edge storage view: forwarded data plus next-state valid.
    always_comb begin
      rd_data_p0  = '0;
      rd_valid_p0 = '0;
      for (int p = 0; p < NUM_RD; p++) begin
        rd_data_p0[p*DATA_W +: DATA_W] = mem[rd_addr[p*PREG_W +: PREG_W]];
        rd_valid_p0[p]                 = vld_nxt[rd_addr[p*PREG_W +: PREG_W]];
        for (int j = NUM_WB - 1; j >= 0; j--)
          if (wb_en[j] && wb_addr[j*PREG_W +: PREG_W] == rd_addr[p*PREG_W +: PREG_W])
            rd_data_p0[p*DATA_W +: DATA_W] = wb_data[j*DATA_W +: DATA_W];
        if (rd_addr[p*PREG_W +: PREG_W] == '0) rd_data_p0[p*DATA_W +: DATA_W] = '0;
      end
    end

    // ---- registered read stage ----
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_data_p1  <= '0;
        rd_valid_p1 <= '0;
      end else begin
        rd_data_p1  <= rd_data_p0;
        rd_valid_p1 <= rd_valid_p0;
      end
    end

    assign rd_data  = rd_data_p1;
    assign rd_valid = rd_valid_p1;
  end

endmodule
